// File: rtl/bcd_display_driver_2digit.sv
// Two-digit multiplexed 7-segment driver for a packed BCD value.
// A load strobe latches the value. The scan shows the units digit, a one-cycle
// dark gap, the tens digit, then another dark gap. All pins are registered, so
// seg and digit_en always change together.
module bcd_display_driver_2digit #(
    parameter int SCAN_PERIOD        = 25000,
    parameter bit SEG_ACTIVE_LOW     = 1'b1,
    parameter bit BLANK_LEADING_ZERO = 1'b1
) (
    input  logic       CLK_50M,
    input  logic       RESET,
    input  logic [7:0] bcd_in,
    input  logic       load,
    output logic [6:0] seg,
    output logic [1:0] digit_en,
    output logic       error
);

    localparam int              CNT_W    = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_PERIOD - 1);
    localparam logic [6:0]      SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    typedef enum logic [1:0] {
        SHOW_UNITS = 2'd0,
        GAP_T      = 2'd1,
        SHOW_TENS  = 2'd2,
        GAP_U      = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic [7:0]         value_q, value_d;
    logic               error_q, error_d;
    logic [6:0]         seg_q, seg_d;
    logic [1:0]         digit_en_q, digit_en_d;

    // Per-nibble decode results: [0] = units, [1] = tens
    logic [6:0]         digit_pat [2];
    logic [1:0]         latched_zero;
    logic [1:0]         incoming_bad;
    logic [6:0]         seg_raw;

    // Active-high segment pattern {g,f,e,d,c,b,a}; non-BCD nibbles show a dash
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            default: pat = 7'h40;
        endcase
        return pat;
    endfunction

    // Decode both latched nibbles for display and check both incoming nibbles
    // so the error flag can be updated on the same edge as the load
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_nibble
            assign digit_pat[gi]    = seg_decode(value_q[4*gi +: 4]);
            assign latched_zero[gi] = (value_q[4*gi +: 4] == 4'd0);
            assign incoming_bad[gi] = (bcd_in[4*gi +: 4] > 4'd9);
        end
    endgenerate

    // Scan sequencer: each SHOW state lasts SCAN_PERIOD cycles, each GAP lasts one
    always_comb begin
        state_d    = state_q;
        scan_cnt_d = scan_cnt_q;
        case (state_q)
            SHOW_UNITS: begin
                if (scan_cnt_q == CNT_LAST) begin
                    scan_cnt_d = '0;
                    state_d    = GAP_T;
                end else begin
                    scan_cnt_d = scan_cnt_q + 1'b1;
                end
            end
            GAP_T: begin
                scan_cnt_d = '0;
                state_d    = SHOW_TENS;
            end
            SHOW_TENS: begin
                if (scan_cnt_q == CNT_LAST) begin
                    scan_cnt_d = '0;
                    state_d    = GAP_U;
                end else begin
                    scan_cnt_d = scan_cnt_q + 1'b1;
                end
            end
            GAP_U: begin
                scan_cnt_d = '0;
                state_d    = SHOW_UNITS;
            end
            default: begin
                scan_cnt_d = '0;
                state_d    = SHOW_UNITS;
            end
        endcase
    end

    // Pin values for the next cycle come from the current state and latched value
    always_comb begin
        digit_en_d = 2'b00;
        seg_raw    = 7'h00;
        case (state_q)
            SHOW_UNITS: begin
                // Units is always lit, so a value of 00 still shows "0"
                digit_en_d = 2'b01;
                seg_raw    = digit_pat[0];
            end
            SHOW_TENS: begin
                // A blanked tens digit keeps its slot timing; it just stays dark
                if (!(BLANK_LEADING_ZERO && latched_zero[1])) begin
                    digit_en_d = 2'b10;
                    seg_raw    = digit_pat[1];
                end
            end
            default: begin
                digit_en_d = 2'b00;
                seg_raw    = 7'h00;
            end
        endcase
        seg_d = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    end

    // Load path: any state may accept a load; the scan position is not disturbed
    always_comb begin
        value_d = value_q;
        error_d = error_q;
        if (load) begin
            value_d = bcd_in;
            error_d = |incoming_bad;
        end
    end

    // All state and pins; reset takes priority over a simultaneous load
    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            state_q    <= SHOW_UNITS;
            scan_cnt_q <= '0;
            value_q    <= 8'h00;
            error_q    <= 1'b0;
            seg_q      <= SEG_OFF;
            digit_en_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            scan_cnt_q <= scan_cnt_d;
            value_q    <= value_d;
            error_q    <= error_d;
            seg_q      <= seg_d;
            digit_en_q <= digit_en_d;
        end
    end

    assign seg      = seg_q;
    assign digit_en = digit_en_q;
    assign error    = error_q;

endmodule
